// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO output arbiter.
// The FSM state enum includes READ, which is reachable only when PIO_ARB_READBACK_EN is defined.
package pio_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WRITE,
        READ,
        ACK
    } state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_W_DEFAULT = 4;

endpackage

// File: rtl/pio_out_arbiter_if.sv
// Avalon-MM write/read signals between the arbiter (master) and the output PIO (slave).
interface pio_out_arbiter_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/pio_out_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr_i, wrapping
// from N_REQ-1 back to 0. Returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            cand = pos[IDX_W-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_out_arbiter.sv
// Round-robin arbiter merging masked bit updates from N_REQ agents into one Avalon PIO write.
// Define PIO_ARB_READBACK_EN to add a verify read after each write and a sticky readback_err.
module pio_out_arbiter
    import pio_arb_pkg::*;
#(
    parameter int         N_REQ     = 4,
    parameter int         PIO_W     = PIO_W_DEFAULT,
    parameter logic [1:0] DATA_ADDR = PIO_DATA_ADDR
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PIO_W-1:0] req_mask,
    input  logic [N_REQ*PIO_W-1:0] req_data,
    output logic [N_REQ-1:0]       ack,
    pio_out_arbiter_if.master      bus,
    output logic [PIO_W-1:0]       shadow_out,
`ifdef PIO_ARB_READBACK_EN
    output logic                   readback_err,
`endif
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic [PIO_W-1:0] nv_q;
    logic [PIO_W-1:0] shadow_q;
    logic [PIO_W-1:0] wdata_q;
    logic             cs_q;
    logic             wn_q;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic [PIO_W-1:0] sel_mask;
    logic [PIO_W-1:0] sel_data;
    logic [PIO_W-1:0] nv_d;
    logic [IDX_W-1:0] ptr_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        sel_mask = req_mask[int'(arb_idx)*PIO_W +: PIO_W];
        sel_data = req_data[int'(arb_idx)*PIO_W +: PIO_W];
        nv_d     = (shadow_q & ~sel_mask) | (sel_data & sel_mask);
        ptr_d    = (int'(arb_idx) == N_REQ-1) ? '0 : arb_idx + 1'b1;
    end

`ifdef PIO_ARB_READBACK_EN
    logic rb_err_q;
`else
    logic unused_rd;
    assign unused_rd = ^bus.avm_readdata;
`endif

    // NOTE: state is updated with non-blocking assignments only; reset is asynchronous and
    // aborts any transaction in flight without an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            nv_q     <= '0;
            shadow_q <= '0;
            wdata_q  <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
`ifdef PIO_ARB_READBACK_EN
            rb_err_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            cs_q  <= 1'b0;
            wn_q  <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (|req) state_q <= GRANT;
                end
                GRANT: begin
                    if (!arb_valid) begin
                        state_q <= IDLE;
                    end else begin
                        gnt_q <= arb_grant;
                        nv_q  <= nv_d;
                        ptr_q <= ptr_d;
                        if (|sel_mask) begin
                            state_q <= WRITE;
                            cs_q    <= 1'b1;
                            wn_q    <= 1'b0;
                            wdata_q <= nv_d;
                        end else begin
                            state_q <= ACK;
                            ack_q   <= arb_grant;
                        end
                    end
                end
                WRITE: begin
                    shadow_q <= nv_q;
`ifdef PIO_ARB_READBACK_EN
                    state_q  <= READ;
                    cs_q     <= 1'b1;
`else
                    state_q  <= ACK;
                    ack_q    <= gnt_q;
`endif
                end
`ifdef PIO_ARB_READBACK_EN
                READ: begin
                    if (bus.avm_readdata[PIO_W-1:0] != nv_q) rb_err_q <= 1'b1;
                    state_q <= ACK;
                    ack_q   <= gnt_q;
                end
`endif
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack                = ack_q;
    assign shadow_out         = shadow_q;
    assign busy               = (state_q != IDLE);
    assign bus.avm_address    = DATA_ADDR;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = wn_q;
    assign bus.avm_writedata  = {{(32-PIO_W){1'b0}}, wdata_q};
`ifdef PIO_ARB_READBACK_EN
    assign readback_err       = rb_err_q;
`endif

endmodule

// File: tb/tb_pio_out_arbiter.sv
// Directed bench for pio_out_arbiter with a simple output-PIO model on the slave side.
// Works with or without PIO_ARB_READBACK_EN (adds one READ cycle per write).
module tb_pio_out_arbiter;

`ifdef PIO_ARB_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_mask;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  shadow_out;
    logic        busy;
    logic        readback_err;
    logic [3:0]  pio_q;
    logic        bad_rd;
    logic [3:0]  shadow_mdl;
    int          n_tests;
    int          n_fail;

    pio_out_arbiter_if bus ();

    pio_out_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_mask     (req_mask),
        .req_data     (req_data),
        .ack          (ack),
        .bus          (bus.master),
        .shadow_out   (shadow_out),
`ifdef PIO_ARB_READBACK_EN
        .readback_err (readback_err),
`endif
        .busy         (busy)
    );

`ifndef PIO_ARB_READBACK_EN
    assign readback_err = 1'b0;
`endif

    // Output PIO: data register at address 0, reset to 0; readback can be forced wrong.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_q <= 4'h0;
        else if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd0)
            pio_q <= bus.avm_writedata[3:0];
    end
    assign bus.avm_readdata = bad_rd ? 32'h0000_000F : {28'h0, pio_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One requester transaction started in IDLE; checks bus activity and the ack cycle.
    task automatic do_req(input int r, input logic [3:0] m, input logic [3:0] d,
                          input bit drop_in_write, input string tag);
        logic [3:0] exp_nv;
        logic [3:0] one;
        exp_nv = (shadow_mdl & ~m) | (d & m);
        one    = 4'b0001 << r;
        req_mask[r*4 +: 4] = m;
        req_data[r*4 +: 4] = d;
        req[r] = 1'b1;
        tick();
        check({tag, "_busy_grant"}, 32'(busy), 32'd1);
        check({tag, "_cs_grant"}, 32'(bus.avm_chipselect), 32'd0);
        if (m != 4'd0) begin
            tick();
            check({tag, "_cs_write"}, 32'(bus.avm_chipselect), 32'd1);
            check({tag, "_wn_write"}, 32'(bus.avm_write_n), 32'd0);
            check({tag, "_addr"}, 32'(bus.avm_address), 32'd0);
            check({tag, "_wdata"}, bus.avm_writedata, {28'h0, exp_nv});
            check({tag, "_ack_write"}, 32'(ack), 32'd0);
            if (drop_in_write) req[r] = 1'b0;
`ifdef PIO_ARB_READBACK_EN
            tick();
            check({tag, "_cs_read"}, 32'(bus.avm_chipselect), 32'd1);
            check({tag, "_wn_read"}, 32'(bus.avm_write_n), 32'd1);
`endif
        end
        tick();
        check({tag, "_ack"}, 32'(ack), 32'(one));
        check({tag, "_cs_ack"}, 32'(bus.avm_chipselect), 32'd0);
        check({tag, "_wn_ack"}, 32'(bus.avm_write_n), 32'd1);
        req[r] = 1'b0;
        shadow_mdl = exp_nv;
        tick();
        check({tag, "_ack_off"}, 32'(ack), 32'd0);
        check({tag, "_shadow"}, 32'(shadow_out), 32'(exp_nv));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    // Advance n cycles; ack must be low before the last one and equal exp on it.
    task automatic wait_ack(input int n, input logic [3:0] exp, input string tag);
        for (int c = 1; c < n; c++) begin
            tick();
            check({tag, "_quiet"}, 32'(ack), 32'd0);
        end
        tick();
        check(tag, 32'(ack), 32'(exp));
    endtask

    initial begin
        int last;
        logic [3:0] exp_ack;
        n_tests    = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        req        = '0;
        req_mask   = '0;
        req_data   = '0;
        bad_rd     = 1'b0;
        shadow_mdl = 4'h0;
        tick();
        tick();
        check("rst_shadow", 32'(shadow_out), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rst_wn", 32'(bus.avm_write_n), 32'd1);
        check("rst_addr", 32'(bus.avm_address), 32'd0);
        check("rst_wdata", bus.avm_writedata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rberr", 32'(readback_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // Build shadow 4'b1100, then the single-update vector: expect writedata 0xD.
        do_req(0, 4'b1100, 4'b1100, 1'b0, "setup");
        do_req(0, 4'b0011, 4'b0001, 1'b0, "single");
        check("single_hand_shadow", 32'(shadow_out), 32'h0000_000D);
        check("single_pio", 32'(pio_q), 32'h0000_000D);

        // Empty mask: no bus cycle, ack at cycle 2, shadow unchanged.
        do_req(2, 4'b0000, 4'b1111, 1'b0, "mask0");
        check("mask0_hand_shadow", 32'(shadow_out), 32'h0000_000D);

        // req1 withdrawn during WRITE: write and ack still happen (ptr moves to 2).
        do_req(1, 4'b1111, 4'b0010, 1'b1, "drop");
        check("drop_pio", 32'(pio_q), 32'h0000_0002);

        // From ptr=2 with req0 and req2 pending, req2 wins, then req0.
        req_mask = '0;
        req = 4'b0101;
        wait_ack(2, 4'b0100, "ptr2_first");
        req[2] = 1'b0;
        wait_ack(3, 4'b0001, "ptr2_second");
        req = '0;
        tick();
        check("ptr2_shadow", 32'(shadow_out), 32'h0000_0002);

        // Reset asserted during a WRITE cycle aborts the transaction.
        req_mask[15:12] = 4'hF;
        req_data[15:12] = 4'hA;
        req[3] = 1'b1;
        tick();
        tick();
        check("rstw_cs_write", 32'(bus.avm_chipselect), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstw_shadow", 32'(shadow_out), 32'd0);
        check("rstw_wn", 32'(bus.avm_write_n), 32'd1);
        check("rstw_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rstw_ack", 32'(ack), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        req = '0;
        tick();
        tick();
        check("rstw_ack_hold", 32'(ack), 32'd0);
        check("rstw_pio", 32'(pio_q), 32'd0);
        reset_n = 1'b1;
        shadow_mdl = 4'h0;
        tick();
        check("rstw_ack_after", 32'(ack), 32'd0);

        // All four requesting continuously from ptr=0: acks 0,1,2,3,0 at a fixed period.
        req_mask = 16'hFFFF;
        req_data = 16'hBA98;
        req = 4'b1111;
        last = 3 + RB + 4 * (4 + RB);
        for (int c = 1; c <= last; c++) begin
            tick();
            exp_ack = 4'b0000;
            if (c >= 3 + RB && (c - 3 - RB) % (4 + RB) == 0)
                exp_ack = 4'b0001 << (((c - 3 - RB) / (4 + RB)) % 4);
            check($sformatf("rr_c%0d", c), 32'(ack), 32'(exp_ack));
        end
        req = '0;
        tick();
        check("rr_shadow", 32'(shadow_out), 32'h0000_0008);
        check("rr_busy", 32'(busy), 32'd0);
        shadow_mdl = 4'h8;

`ifdef PIO_ARB_READBACK_EN
        check("rb_clean", 32'(readback_err), 32'd0);
        bad_rd = 1'b1;
        do_req(0, 4'hF, 4'h5, 1'b0, "rb_bad");
        bad_rd = 1'b0;
        check("rb_err_set", 32'(readback_err), 32'd1);
        do_req(1, 4'hF, 4'h3, 1'b0, "rb_good");
        check("rb_err_sticky", 32'(readback_err), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
